pipe_stage_rv: RTL and testbench
================================

# pipe_stage_rv

Parametrised pipeline stage register: the successor to the plain always-load stage flop between pipeline stages. Adds valid tracking, ready/valid back-pressure, an optional 2-entry skid buffer and a synchronous flush. With it the Fetch/Decode/Execute/Memory/Writeback boundaries can stall and squash. One instance per stage boundary; payload is the packed stage bundle (e.g. 100-bit D->E, 68-bit E->M).

## Interface
- W, 32: payload width in bits (>=1).
- ELASTIC, 1: 1 = skid mode, in_ready registered; 0 = single-entry mode, in_ready combinational from out_ready.
- RESET_VAL, {W{1'b0}}: value of out_data after reset and flush.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous squash of every held entry (branch taken / exception).
- in_valid  in  1  upstream has payload.
- in_ready  out  1  stage accepts payload this cycle.
- in_data  in  W  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream consumes this cycle (deasserted = stall).
- out_data  out  W  payload presented downstream.
- level  out  2  entries held: 0, 1 or 2 (2 only when ELASTIC=1).

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data); skid register (ELASTIC=1 only).
- FSM states: EMPTY (level 0), BUSY (level 1), FULL (level 2, ELASTIC=1 only).
- EMPTY: in_fire -> BUSY, main <= in_data.
- BUSY with in_fire & out_fire -> BUSY, main <= in_data.
- BUSY with in_fire & !out_ready -> FULL, skid <= in_data (ELASTIC=1). With ELASTIC=0 this case cannot occur, because in_ready is 0.
- BUSY with !in_fire & out_fire -> EMPTY.
- BUSY with no fire: hold.
- FULL with out_fire -> BUSY, main <= skid. No input is accepted in FULL.
- Outputs, ELASTIC=1: in_ready = registered (next_state != FULL); out_valid = state != EMPTY.
- Outputs, ELASTIC=0: in_ready = !out_valid | out_ready (combinational path).
- Payload rules:
  - out_data is stable while out_valid & !out_ready.
  - Order is strictly FIFO; no entry is dropped or duplicated except by flush.
- Flush: next state EMPTY, main <= RESET_VAL, level 0. Any in_fire in the same cycle is discarded. out_fire in the flush cycle still counts as consumed downstream. ELASTIC=1: in_ready = 1 the cycle after.
- Priority: reset > flush > normal transitions.

## Timing
- Latency: 1 cycle in_fire -> out_valid in both modes. Throughput: 1 entry/cycle while out_ready is held high.
- ELASTIC=1: in_ready deasserts the cycle after a stall fills the skid register. The one in-flight beat lands in skid. out_ready -> in_ready has no combinational path.
- Reset values: out_valid 0, level 0, out_data RESET_VAL, skid RESET_VAL. in_ready is 1 the cycle after reset releases (ELASTIC=1). With ELASTIC=0 in_ready is combinationally 1 whenever out_valid is 0, so it is also 1 after reset.
- Reset or flush asserted mid-stall (FULL) drops both entries. No stale payload appears on any later out_fire.
- out_ready toggling while state is EMPTY has no effect.

## Structure
- Shared header pipe_defs.vh holds:
  - localparams ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2;
  - level encodings;
  - the stage bundle widths (DE_W=100, EM_W=68, MW_W=68) used by datapath instantiations.
- One sub-module, pipe_stage_fsm: holds state, in_ready, level and the main/skid load enables. The top holds the W-wide main and skid registers and the ELASTIC generate branch.
- The skid register is not instantiated when ELASTIC=0.

## Test plan
- Streaming, W=32, ELASTIC=1: in_valid held 1, in_data 1,2,3,4, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles one cycle later; level stays 1.
- Stall fill: send 0xA then 0xB with out_ready=0 -> level=2, in_ready=0. Hold 0xC on input for 3 cycles -> 0xC not accepted. Raise out_ready -> 0xA, 0xB, 0xC emerge in order.
- Flush in FULL: entries 0x11, 0x22 held; flush=1 together with in_valid=1, in_data=0x33 -> next cycle out_valid=0, level=0, out_data=RESET_VAL; 0x33 never appears.
- ELASTIC=0, W=68: in_ready must equal !out_valid|out_ready in the same cycle. Stall 2 cycles -> out_data holds 68'h1_0000_0000_DEAD_BEEF unchanged.
- Reset while BUSY with out_ready=0 -> next cycle out_valid=0, level=0, out_data=RESET_VAL, in_ready=1.
- Random in_valid/out_ready for 10k cycles, both modes: scoreboard checks FIFO order, no loss or duplication, and level = accepted - consumed.

Source files
------------

// File: rtl/pipe_stage_rv_pkg.sv
// Shared types and constants for the pipeline stage register and its control FSM.
package pipe_stage_rv_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [1:0] LVL_EMPTY = 2'd0;
  localparam logic [1:0] LVL_ONE   = 2'd1;
  localparam logic [1:0] LVL_TWO   = 2'd2;

  // Stage bundle widths used by the datapath instantiations.
  localparam int unsigned DE_W = 100;
  localparam int unsigned EM_W = 68;
  localparam int unsigned MW_W = 68;

  function automatic logic [1:0] state_level(input state_e s);
    case (s)
      ST_BUSY: return LVL_ONE;
      ST_FULL: return LVL_TWO;
      default: return LVL_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_rv_fsm.sv
// Control for pipe_stage_rv: occupancy state, in_ready, level and the payload load enables.
module pipe_stage_fsm
  import pipe_stage_rv_pkg::*;
#(
  parameter bit ELASTIC = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] level,
  output logic       load_main,
  output logic       main_from_skid,
  output logic       load_skid,
  output logic       clear_main
);

  state_e state_q, state_d;
  logic   in_fire, out_fire;

  assign out_fire = (state_q != ST_EMPTY) & out_ready;
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_BUSY;
        ST_BUSY: begin
          if (ELASTIC && in_fire && !out_ready) state_d = ST_FULL;
          else if (!in_fire && out_fire)        state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_d = ST_BUSY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid      = (state_q != ST_EMPTY);
    level          = state_level(state_q);
    clear_main     = flush;
    main_from_skid = (state_q == ST_FULL);
    load_main      = !flush &&
                     (((state_q == ST_EMPTY) && in_fire) ||
                      ((state_q == ST_BUSY) && in_fire && out_fire) ||
                      ((state_q == ST_FULL) && out_fire));
    load_skid      = !flush && ELASTIC && (state_q == ST_BUSY) && in_fire && !out_ready;
  end

  if (ELASTIC) begin : g_reg_ready
    // Registered from the next state so out_ready never reaches in_ready combinationally.
    logic in_ready_q, in_ready_d;
    always_comb in_ready_d = (state_d != ST_FULL);
    always_ff @(posedge clk) begin
      if (reset) in_ready_q <= 1'b1;
      else       in_ready_q <= in_ready_d;
    end
    assign in_ready = in_ready_q;
  end else begin : g_comb_ready
    assign in_ready = (state_q == ST_EMPTY) | out_ready;
  end

endmodule

// File: rtl/pipe_stage_rv.sv
// Pipeline stage register with valid tracking, ready/valid back-pressure, optional skid entry and flush.
module pipe_stage_rv
  import pipe_stage_rv_pkg::*;
#(
  parameter int unsigned     W         = 32,
  parameter bit              ELASTIC   = 1'b1,
  parameter logic [W-1:0]    RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   level
);

  logic         load_main, main_from_skid, load_skid, clear_main;
  logic [W-1:0] main_q, main_d, skid_data;

  pipe_stage_fsm #(
    .ELASTIC(ELASTIC)
  ) u_fsm (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .out_ready     (out_ready),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .level         (level),
    .load_main     (load_main),
    .main_from_skid(main_from_skid),
    .load_skid     (load_skid),
    .clear_main    (clear_main)
  );

  always_comb begin
    main_d = main_q;
    if (clear_main)     main_d = RESET_VAL;
    else if (load_main) main_d = main_from_skid ? skid_data : in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) main_q <= RESET_VAL;
    else       main_q <= main_d;
  end

  assign out_data = main_q;

  if (ELASTIC) begin : g_skid
    logic [W-1:0] skid_q, skid_d;
    always_comb skid_d = load_skid ? in_data : skid_q;
    always_ff @(posedge clk) begin
      if (reset) skid_q <= RESET_VAL;
      else       skid_q <= skid_d;
    end
    assign skid_data = skid_q;
  end else begin : g_no_skid
    logic unused_load_skid;
    assign unused_load_skid = load_skid;
    assign skid_data        = RESET_VAL;
  end

endmodule

// File: tb/tb_pipe_stage_rv.sv
// Bench for pipe_stage_rv: directed vector tables for both modes, then randomized traffic against a queue model.
module tb_pipe_stage_rv;

  localparam logic [31:0] RV_E = 32'hDEAD_0000;
  localparam logic [67:0] RV_N = 68'hF_0000_0000_0000_0000;
  localparam logic [67:0] V_N  = 68'h1_0000_0000_DEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        e_reset = 1'b1, e_flush = 1'b0, e_in_valid = 1'b0, e_out_ready = 1'b0;
  logic [31:0] e_in_data = '0;
  logic        e_in_ready, e_out_valid;
  logic [31:0] e_out_data;
  logic [1:0]  e_level;

  logic        n_reset = 1'b1, n_flush = 1'b0, n_in_valid = 1'b0, n_out_ready = 1'b0;
  logic [67:0] n_in_data = '0;
  logic        n_in_ready, n_out_valid;
  logic [67:0] n_out_data;
  logic [1:0]  n_level;

  pipe_stage_rv #(.W(32), .ELASTIC(1'b1), .RESET_VAL(RV_E)) u_el (
    .clk(clk), .reset(e_reset), .flush(e_flush), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .in_data(e_in_data), .out_valid(e_out_valid), .out_ready(e_out_ready),
    .out_data(e_out_data), .level(e_level));

  pipe_stage_rv #(.W(68), .ELASTIC(1'b0), .RESET_VAL(RV_N)) u_ne (
    .clk(clk), .reset(n_reset), .flush(n_flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_data(n_in_data), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_data(n_out_data), .level(n_level));

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic rst, fl, iv;
    logic [67:0] id;
    logic orr;
    logic chk, chk_d;
    logic ov;
    logic [1:0] lvl;
    logic ir;
    logic [67:0] d;
  } vec_t;

  vec_t ev[$];
  vec_t nv[$];

  function automatic vec_t mk(input logic rst, fl, iv, input logic [67:0] id, input logic orr,
                              input logic chk, chk_d, ov, input logic [1:0] lvl,
                              input logic ir, input logic [67:0] d);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.orr = orr;
    v.chk = chk; v.chk_d = chk_d; v.ov = ov; v.lvl = lvl; v.ir = ir; v.d = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1: drive, settle, compare pre-edge outputs, then advance one clock.
  task automatic apply_vec(input bit nmode, input vec_t v, input int idx);
    string p;
    logic ov, ir;
    logic [1:0] lvl;
    logic [67:0] d;
    if (nmode) begin
      n_reset = v.rst; n_flush = v.fl; n_in_valid = v.iv; n_in_data = v.id; n_out_ready = v.orr;
    end else begin
      e_reset = v.rst; e_flush = v.fl; e_in_valid = v.iv; e_in_data = v.id[31:0]; e_out_ready = v.orr;
    end
    #1;
    ov  = nmode ? n_out_valid : e_out_valid;
    ir  = nmode ? n_in_ready  : e_in_ready;
    lvl = nmode ? n_level     : e_level;
    d   = nmode ? n_out_data  : {36'd0, e_out_data};
    p   = $sformatf("%s[%0d]", nmode ? "nvec" : "evec", idx);
    if (v.chk) begin
      check({p, ".out_valid"}, {67'd0, ov}, {67'd0, v.ov});
      check({p, ".level"},     {66'd0, lvl}, {66'd0, v.lvl});
      check({p, ".in_ready"},  {67'd0, ir}, {67'd0, v.ir});
      if (v.chk_d) check({p, ".out_data"}, d, v.d);
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] eq[$];
  logic [67:0] nq[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Elastic, W=32: streaming, stall fill, flush in FULL/BUSY, reset in BUSY, EMPTY out_ready toggle.
    ev.push_back(mk(1,0,0,0,0,   0,0,0,0,0,0));
    ev.push_back(mk(0,0,0,0,1,   1,1,0,0,1,RV_E));
    ev.push_back(mk(0,0,1,1,1,   1,1,0,0,1,RV_E));
    ev.push_back(mk(0,0,1,2,1,   1,1,1,1,1,1));
    ev.push_back(mk(0,0,1,3,1,   1,1,1,1,1,2));
    ev.push_back(mk(0,0,1,4,1,   1,1,1,1,1,3));
    ev.push_back(mk(0,0,0,0,1,   1,1,1,1,1,4));
    ev.push_back(mk(0,0,0,0,0,   1,0,0,0,1,0));
    ev.push_back(mk(0,0,1,'hA,0, 1,0,0,0,1,0));
    ev.push_back(mk(0,0,1,'hB,0, 1,1,1,1,1,'hA));
    ev.push_back(mk(0,0,1,'hC,0, 1,1,1,2,0,'hA));
    ev.push_back(mk(0,0,1,'hC,0, 1,1,1,2,0,'hA));
    ev.push_back(mk(0,0,1,'hC,0, 1,1,1,2,0,'hA));
    ev.push_back(mk(0,0,1,'hC,1, 1,1,1,2,0,'hA));
    ev.push_back(mk(0,0,1,'hC,1, 1,1,1,1,1,'hB));
    ev.push_back(mk(0,0,0,0,1,   1,1,1,1,1,'hC));
    ev.push_back(mk(0,0,0,0,0,   1,0,0,0,1,0));
    ev.push_back(mk(0,0,1,'h11,0,1,0,0,0,1,0));
    ev.push_back(mk(0,0,1,'h22,0,1,1,1,1,1,'h11));
    ev.push_back(mk(0,1,1,'h33,0,1,1,1,2,0,'h11));
    ev.push_back(mk(0,0,0,0,1,   1,1,0,0,1,RV_E));
    ev.push_back(mk(0,0,0,0,1,   1,1,0,0,1,RV_E));
    ev.push_back(mk(0,0,1,'h44,0,1,0,0,0,1,0));
    ev.push_back(mk(0,1,1,'h55,0,1,1,1,1,1,'h44));
    ev.push_back(mk(0,0,0,0,1,   1,1,0,0,1,RV_E));
    ev.push_back(mk(0,0,1,'h66,0,1,0,0,0,1,0));
    ev.push_back(mk(1,0,0,0,0,   1,1,1,1,1,'h66));
    ev.push_back(mk(0,0,0,0,0,   1,1,0,0,1,RV_E));
    ev.push_back(mk(0,0,0,0,1,   1,1,0,0,1,RV_E));
    ev.push_back(mk(0,0,0,0,0,   1,1,0,0,1,RV_E));

    // Single-entry, W=68: combinational in_ready, 2-cycle stall, reset and flush in BUSY.
    nv.push_back(mk(1,0,0,0,0,   0,0,0,0,0,0));
    nv.push_back(mk(0,0,0,0,0,   1,1,0,0,1,RV_N));
    nv.push_back(mk(0,0,1,V_N,0, 1,1,0,0,1,RV_N));
    nv.push_back(mk(0,0,1,2,0,   1,1,1,1,0,V_N));
    nv.push_back(mk(0,0,1,2,0,   1,1,1,1,0,V_N));
    nv.push_back(mk(0,0,1,2,1,   1,1,1,1,1,V_N));
    nv.push_back(mk(0,0,0,0,1,   1,1,1,1,1,2));
    nv.push_back(mk(0,0,0,0,0,   1,0,0,0,1,0));
    nv.push_back(mk(0,0,1,3,1,   1,0,0,0,1,0));
    nv.push_back(mk(1,0,0,0,0,   1,1,1,1,0,3));
    nv.push_back(mk(0,0,0,0,0,   1,1,0,0,1,RV_N));
    nv.push_back(mk(0,0,1,4,0,   1,1,0,0,1,RV_N));
    nv.push_back(mk(0,1,1,5,1,   1,1,1,1,1,4));
    nv.push_back(mk(0,0,0,0,0,   1,1,0,0,1,RV_N));

    @(posedge clk);
    #1;
    foreach (ev[i]) apply_vec(1'b0, ev[i], i);
    foreach (nv[i]) apply_vec(1'b1, nv[i], i);

    // Randomized traffic on both instances against a FIFO-queue model.
    e_reset = 1'b1; n_reset = 1'b1; e_flush = 1'b0; n_flush = 1'b0;
    e_in_valid = 1'b0; n_in_valid = 1'b0;
    @(posedge clk);
    #1;
    begin
      bit e_clr = 1'b1, n_clr = 1'b1;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        bit e_ov_x, e_ir_x, n_ov_x, n_ir_x;
        bit e_rst, e_fl, n_rst, n_fl;
        e_rst = ($urandom_range(0, 299) == 0);
        n_rst = ($urandom_range(0, 299) == 0);
        e_fl  = ($urandom_range(0, 63) == 0);
        n_fl  = ($urandom_range(0, 63) == 0);
        e_reset = e_rst; e_flush = e_fl;
        n_reset = n_rst; n_flush = n_fl;
        e_in_valid  = ($urandom_range(0, 3) != 0);
        n_in_valid  = ($urandom_range(0, 3) != 0);
        e_out_ready = ($urandom_range(0, 2) != 0);
        n_out_ready = ($urandom_range(0, 2) != 0);
        e_in_data   = $urandom;
        n_in_data   = {4'($urandom), $urandom, $urandom};
        #1;
        e_ov_x = (eq.size() != 0);
        e_ir_x = (eq.size() < 2);
        n_ov_x = (nq.size() != 0);
        n_ir_x = (nq.size() == 0) || n_out_ready;
        check("rand_e.out_valid", {67'd0, e_out_valid}, {67'd0, e_ov_x});
        check("rand_e.in_ready",  {67'd0, e_in_ready},  {67'd0, e_ir_x});
        check("rand_e.level",     {66'd0, e_level},     68'(eq.size()));
        if (e_ov_x)     check("rand_e.out_data", {36'd0, e_out_data}, {36'd0, eq[0]});
        else if (e_clr) check("rand_e.out_data", {36'd0, e_out_data}, {36'd0, RV_E});
        check("rand_n.out_valid", {67'd0, n_out_valid}, {67'd0, n_ov_x});
        check("rand_n.in_ready",  {67'd0, n_in_ready},  {67'd0, n_ir_x});
        check("rand_n.level",     {66'd0, n_level},     68'(nq.size()));
        if (n_ov_x)     check("rand_n.out_data", n_out_data, nq[0]);
        else if (n_clr) check("rand_n.out_data", n_out_data, RV_N);
        @(posedge clk);
        #1;
        if (e_rst || e_fl) begin
          eq.delete();
          e_clr = 1'b1;
        end else begin
          if (e_ov_x && e_out_ready) void'(eq.pop_front());
          if (e_in_valid && e_ir_x) begin
            eq.push_back(e_in_data);
            e_clr = 1'b0;
          end
        end
        if (n_rst || n_fl) begin
          nq.delete();
          n_clr = 1'b1;
        end else begin
          if (n_ov_x && n_out_ready) void'(nq.pop_front());
          if (n_in_valid && n_ir_x) begin
            nq.push_back(n_in_data);
            n_clr = 1'b0;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
